program_loader_mem: RTL

//  Program memory feeding the control unit's PM_data/PC fetch port, plus a byte-stream loader FSM.
//  The loader receives a program image (length, big-endian 16-bit words) over a valid/ready byte

---
 rtl/program_loader_mem.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/program_loader_mem.sv
// program_loader_mem: program memory with a combinational fetch port and a
// byte-stream loader FSM that writes a big-endian 16-bit word image into it.
// The loader keeps the core held (cpu_hold) while an image is being written.
// Optional feature macro: LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
module program_loader_mem #(
    parameter int PC_WIDTH = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PC_WIDTH-1:0] PC,
    output logic [15:0]         PM_data,
    input  logic                load_start,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    output logic                byte_ready,
    output logic                cpu_hold,
    output logic                load_done,
    output logic                load_error,
    output logic [PC_WIDTH:0]   word_count
);

    localparam int               DEPTH     = 1 << PC_WIDTH;
    localparam logic [PC_WIDTH:0] DEPTH_LEN = (PC_WIDTH+1)'(DEPTH);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN   = 3'd1;
    localparam logic [2:0] S_HI    = 3'd2;
    localparam logic [2:0] S_LO    = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHK   = 3'd5;
`endif
    localparam logic [2:0] S_DONE  = 3'd6;
    localparam logic [2:0] S_ERROR = 3'd7;

    logic [15:0] mem [DEPTH];

    logic [2:0]          state_q, state_d;
    logic [7:0]          hi_q, hi_d;
    logic [7:0]          lo_q, lo_d;
    logic [PC_WIDTH-1:0] addr_q, addr_d;
    logic [PC_WIDTH:0]   len_q, len_d;
    logic [PC_WIDTH:0]   wc_q, wc_d;
    logic                ready_q, ready_d;
    logic                hold_q, hold_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                wr_en;
    logic [PC_WIDTH:0]   wc_inc;
    logic                xfer;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]          chk_q, chk_d;
`endif

    assign PM_data    = mem[PC];
    assign byte_ready = ready_q;
    assign cpu_hold   = hold_q;
    assign load_done  = done_q;
    assign load_error = err_q;
    assign word_count = wc_q;
    assign xfer       = byte_valid & ready_q;
    assign wc_inc     = wc_q + 1'b1;

    // Next-state logic for the loader; byte_ready is derived from the next state
    // so that it is a registered function of state alone.
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        addr_d  = addr_q;
        len_d   = len_q;
        wc_d    = wc_q;
        hold_d  = hold_q;
        done_d  = done_q;
        err_d   = err_q;
        wr_en   = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        chk_d   = chk_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (load_start) begin
                    state_d = S_LEN;
                    hold_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    wc_d    = '0;
                    addr_d  = '0;
`ifdef LOADER_CHECKSUM_EN
                    chk_d   = 8'h00;
`endif
                end
            end
            S_LEN: begin
                if (xfer) begin
`ifdef LOADER_CHECKSUM_EN
                    chk_d = byte_in;
`endif
                    // A zero length byte stands for a full-depth image
                    len_d = (byte_in == 8'h00) ? DEPTH_LEN : (PC_WIDTH+1)'(32'(byte_in));
                    if (32'(byte_in) > DEPTH) begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end else begin
                        state_d = S_HI;
                    end
                end
            end
            S_HI: begin
                if (xfer) begin
                    hi_d    = byte_in;
                    state_d = S_LO;
`ifdef LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ byte_in;
`endif
                end
            end
            S_LO: begin
                if (xfer) begin
                    lo_d    = byte_in;
                    state_d = S_WRITE;
`ifdef LOADER_CHECKSUM_EN
                    chk_d   = chk_q ^ byte_in;
`endif
                end
            end
            S_WRITE: begin
                wr_en  = 1'b1;
                addr_d = addr_q + 1'b1;
                wc_d   = wc_inc;
                if (wc_inc == len_q) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
`endif
                end else begin
                    state_d = S_HI;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                if (xfer) begin
                    if (byte_in == chk_q) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                    end else begin
                        state_d = S_ERROR;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
`ifdef LOADER_CHECKSUM_EN
        ready_d = (state_d == S_LEN) || (state_d == S_HI) || (state_d == S_LO) || (state_d == S_CHK);
`else
        ready_d = (state_d == S_LEN) || (state_d == S_HI) || (state_d == S_LO);
`endif
    end

    // Loader state registers; reset abandons any load in progress.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            wc_q    <= '0;
            ready_q <= 1'b0;
            hold_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wc_q    <= wc_d;
            ready_q <= ready_d;
            hold_q  <= hold_d;
            done_q  <= done_d;
            err_q   <= err_d;
`ifdef LOADER_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    // Memory write port; contents deliberately survive reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[addr_q] <= {hi_q, lo_q};
        end
    end

endmodule
